// File: rtl/fetch_pkg.sv
// Shared constants and state type for the IF-stage fetch controller.
package fetch_pkg;

    localparam int unsigned XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;   // addi x0,x0,0
    localparam logic [XLEN-1:0] PC_INCR = 32'd4;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        HOLD,
        DROP
    } fetch_state_e;

endpackage

// File: rtl/fetch_ctrl_if.sv
// PC register, redirect, hazard, imem and IF/ID signals of the fetch controller.
interface fetch_ctrl_if;
    import fetch_pkg::*;

    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_next;
    logic            pc_stall;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_target;
    logic            dec_stall;
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_gnt;
    logic            imem_rvalid;
    logic [XLEN-1:0] imem_rdata;
    logic            if_valid;
    logic [XLEN-1:0] if_instr;
    logic [XLEN-1:0] if_pc;

    // Fetch controller side.
    modport master (
        input  pc, redirect_valid, redirect_target, dec_stall,
               imem_gnt, imem_rvalid, imem_rdata,
        output pc_next, pc_stall, imem_req, imem_addr, if_valid, if_instr, if_pc
    );

    // Surrounding pipeline / memory side.
    modport slave (
        output pc, redirect_valid, redirect_target, dec_stall,
               imem_gnt, imem_rvalid, imem_rdata,
        input  pc_next, pc_stall, imem_req, imem_addr, if_valid, if_instr, if_pc
    );

endinterface

// File: rtl/fetch_ctrl.sv
// IF-stage fetch controller: one outstanding imem request, a one-entry skid
// register for back-pressure, and flush/discard of in-flight fetches on redirect.
module fetch_ctrl
    import fetch_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    fetch_ctrl_if.master bus
);

    fetch_state_e    r_state;
    fetch_state_e    w_state_next;
    logic [XLEN-1:0] r_req_pc;
    logic [XLEN-1:0] r_skid;
    logic            r_if_valid;
    logic [XLEN-1:0] r_if_instr;
    logic [XLEN-1:0] r_if_pc;

    logic            w_imem_req;
    logic            w_slot_free;
    logic            w_load;
    logic [XLEN-1:0] w_load_data;
    logic            w_skid_load;
    logic            w_req_pc_load;
    logic [XLEN-1:0] w_pc_next;
    logic            w_pc_stall;

    assign w_slot_free = !r_if_valid || !bus.dec_stall;

    // Next-PC select: redirect beats sequential advance, which needs a grant.
    always_comb begin
        w_pc_next  = bus.pc;
        w_pc_stall = 1'b1;
        if (bus.redirect_valid) begin
            w_pc_next  = bus.redirect_target;
            w_pc_stall = 1'b0;
        end else if (w_imem_req && bus.imem_gnt) begin
            w_pc_next  = bus.pc + PC_INCR;
            w_pc_stall = 1'b0;
        end
    end

    // Handshake FSM: next state, request strobe and IF/ID load decisions.
    always_comb begin
        w_state_next  = r_state;
        w_imem_req    = 1'b0;
        w_load        = 1'b0;
        w_load_data   = r_skid;
        w_skid_load   = 1'b0;
        w_req_pc_load = 1'b0;
        unique case (r_state)
            IDLE: w_state_next = REQ;
            REQ: begin
                w_imem_req = 1'b1;
                if (bus.imem_gnt) begin
                    if (bus.redirect_valid) begin
                        w_state_next = DROP;   // stale fetch already in flight
                    end else begin
                        w_req_pc_load = 1'b1;
                        w_state_next  = WAIT;
                    end
                end
            end
            WAIT: begin
                if (bus.redirect_valid) begin
                    w_state_next = bus.imem_rvalid ? REQ : DROP;
                end else if (bus.imem_rvalid) begin
                    if (w_slot_free) begin
                        w_load       = 1'b1;
                        w_load_data  = bus.imem_rdata;
                        w_state_next = REQ;
                    end else begin
                        w_skid_load  = 1'b1;
                        w_state_next = HOLD;
                    end
                end
            end
            HOLD: begin
                if (bus.redirect_valid) begin
                    w_state_next = REQ;
                end else if (!bus.dec_stall) begin
                    w_load       = 1'b1;
                    w_state_next = REQ;
                end
            end
            DROP: begin
                if (bus.imem_rvalid) begin
                    w_state_next = REQ;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Address of the in-flight fetch and the skid entry.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_req_pc <= '0;
            r_skid   <= '0;
        end else begin
            if (w_req_pc_load) begin
                r_req_pc <= bus.pc;
            end
            if (w_skid_load) begin
                r_skid <= bus.imem_rdata;
            end
        end
    end

    // IF/ID output slot; a redirect flushes it ahead of any load or stall.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_if_valid <= 1'b0;
            r_if_instr <= NOP_INSTR;
            r_if_pc    <= '0;
        end else if (bus.redirect_valid) begin
            r_if_valid <= 1'b0;
            r_if_instr <= NOP_INSTR;
        end else if (w_load) begin
            r_if_valid <= 1'b1;
            r_if_instr <= w_load_data;
            r_if_pc    <= r_req_pc;
        end else if (r_if_valid && !bus.dec_stall) begin
            r_if_valid <= 1'b0;
        end
    end

    assign bus.imem_req  = w_imem_req;
    assign bus.imem_addr = bus.pc;
    assign bus.pc_next   = w_pc_next;
    assign bus.pc_stall  = w_pc_stall;
    assign bus.if_valid  = r_if_valid;
    assign bus.if_instr  = r_if_instr;
    assign bus.if_pc     = r_if_pc;

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Sequences the program counter register and the instruction-memory request/response handshake in the IF stage of the 5-stage core.
- Drives PC_next/stall into the PC register and delivers fetched instructions to the IF/ID register.
- Accepts branch/jump redirects from EX and back-pressure from the hazard unit; discards in-flight fetches on redirect.
- One outstanding imem request maximum.

Parameters:
- XLEN, 32, address/data width
- NOP_INSTR, 32'h0000_0013, instruction value driven on if_instr when empty/flushed (addi x0,x0,0)

Ports:
- clk  in  1  clock
- reset  in  1  reset
- pc  in  XLEN  current value of the PC register
- pc_next  out  XLEN  next-PC value to the PC register
- pc_stall  out  1  hold PC register when 1
- redirect_valid  in  1  taken branch/jump from EX
- redirect_target  in  XLEN  redirect address
- dec_stall  in  1  IF/ID must hold its contents
- imem_req  out  1  request valid
- imem_addr  out  XLEN  request address
- imem_gnt  in  1  request accepted this cycle
- imem_rvalid  in  1  response valid
- imem_rdata  in  XLEN  response instruction
- if_valid  out  1  if_instr/if_pc valid
- if_instr  out  XLEN  fetched instruction
- if_pc  out  XLEN  PC of if_instr

Behaviour:
- Reset: reset is synchronous, active-high; clock is clk. Reset values: state=IDLE, if_valid=0, if_instr=NOP_INSTR, if_pc=0, req_pc=0, skid empty. imem_req=0 and pc_stall=1 while in IDLE.
- pc_next/pc_stall are combinational:
  - Redirect this cycle: pc_next=redirect_target, pc_stall=0.
  - Else, imem_req&&imem_gnt: pc_next=pc+4 (modulo 2^XLEN, wraps 0xFFFF_FFFC to 0), pc_stall=0.
  - Else: pc_next=pc, pc_stall=1.
- imem_addr=pc, always.
- Output slot free = !if_valid || !dec_stall. Slot consumed = if_valid && !dec_stall; if_valid clears on consumption unless loaded the same cycle.
- IDLE: next cycle go to REQ. A redirect in IDLE updates the PC and still goes to REQ.
- REQ: imem_req=1.
  - gnt, no redirect: req_pc<=pc, go to WAIT.
  - gnt with redirect: go to DROP (the stale fetch is in flight).
  - Redirect without gnt: stay in REQ; imem_addr follows the new pc next cycle.
- WAIT: imem_req=0.
  - On rvalid, slot free: if_instr<=rdata, if_pc<=req_pc, if_valid<=1, go to REQ.
  - On rvalid, slot not free: skid<=rdata, go to HOLD.
  - Redirect without rvalid: go to DROP.
  - Redirect with rvalid: data discarded, go to REQ.
- HOLD: imem_req=0.
  - When !dec_stall: if_instr<=skid, if_pc<=req_pc, if_valid<=1, go to REQ.
  - Redirect: skid discarded, go to REQ.
- DROP: imem_req=0. On rvalid: discard data, go to REQ. A redirect in DROP updates the PC and stays in DROP.
- Any redirect: if_valid<=0 and if_instr<=NOP_INSTR in that cycle (IF/ID flush). Redirect takes priority over dec_stall and over any load.
- imem_rvalid outside WAIT/DROP is ignored (not an error).
- Reset mid-operation returns to IDLE; the imem is reset in the same cycle, so no stale response is expected.
- Throughput: one instruction per 2 cycles minimum with a 1-cycle memory (REQ→WAIT→REQ).

Decomposition:
- fetch_pkg:
  - fetch_state_e enum {IDLE, REQ, WAIT, HOLD, DROP}
  - NOP_INSTR constant
  - XLEN constant
  - PC_INCR=4
- No sub-module. The one-entry skid register is inline, and the FSM is a single always_ff plus one always_comb for next-state and outputs.

Test Plan:
- Reset then free-run, 1-cycle imem (gnt same cycle as req, rvalid next cycle), dec_stall=0 → if_pc sequence 0x0,0x4,0x8 with if_valid pulses every 2 cycles; pc increments on each gnt.
- dec_stall=1 held for 5 cycles while response returns → state HOLD, imem_req=0, if_instr unchanged; on dec_stall=0, the skid instruction appears with if_pc=0x8 next cycle.
- Redirect to 0x100 in WAIT cycle before rvalid → state DROP, next rvalid data (0xDEADBEEF) never appears on if_instr; next imem_addr=0x100, if_pc=0x100 after fetch.
- Redirect to 0x200 coincident with gnt in REQ → pc_next=0x200, pc_stall=0, DROP entered, old response discarded.
- Redirect coincident with rvalid in WAIT, and redirect with dec_stall=1 → if_valid=0, if_instr=0x00000013 next cycle, fetch resumes at target.
- pc=0xFFFF_FFFC granted → pc_next=0x0; gnt held low 3 cycles → imem_req stays 1, pc_stall=1 throughout; assert reset in WAIT → IDLE, if_valid=0.
